// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO between the AGU and the dcache.
// Each entry holds {addr, strb, wdata, uncached}. Loads probe every live
// entry by word address through ld_hit.
// Optional feature macro STB_FWD_EN: when defined, ld_fwd_data/ld_fwd_strb
// carry a byte-wise merge of all matching entries, with the youngest byte
// winning. When undefined, both outputs are tied to zero.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [3:0]  in_strb,
  input  logic [31:0] in_wdata,
  input  logic        in_uncached,
  output logic        dc_valid,
  input  logic        dc_ready,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_strb,
  output logic [31:0] dc_wdata,
  output logic        dc_uncached,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_fwd_data,
  output logic [3:0]  ld_fwd_strb,
  output logic        empty
);

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 4;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] strb;
    logic [DW-1:0] wdata;
    logic          uncached;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_c;
  logic             pop_c;
  logic [DEPTH-1:0] live_c;
  logic             ld_addr_unused;

  // The low two bits of the probe address are byte-lane bits. Matching
  // is done on whole words, so these bits do not take part.
  assign ld_addr_unused = ^ld_addr[1:0];

  // Status flags and handshakes are decoded from the count register only.
  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign dc_valid = (count_q != '0);
  assign empty    = (count_q == '0);
  assign push_c   = in_valid & in_ready & (|in_strb);
  assign pop_c    = dc_valid & dc_ready;

  // The head payload comes straight from the entry registers.
  assign dc_addr     = mem_q[head_q].addr;
  assign dc_strb     = mem_q[head_q].strb;
  assign dc_wdata    = mem_q[head_q].wdata;
  assign dc_uncached = mem_q[head_q].uncached;

  // Next-state for the pointers and the occupancy count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_c) tail_d = tail_q + PTR_W'(1);
    if (pop_c)  head_d = head_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: async clear discards every entry, including a presented head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[tail_q] <= {in_addr, in_strb, in_wdata, in_uncached};
  end

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off    = '0;
    live_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off       = PTR_W'(i) - head_q;
      live_c[i] = (CNT_W'(off) < count_q);
    end
  end

  // Word-granular overlap of the probing load against all live entries.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_c[i] && (mem_q[i].addr[AW-1:2] == ld_addr[AW-1:2])) ld_hit = 1'b1;
    end
  end

`ifdef STB_FWD_EN
  // Walk from oldest to youngest so that younger bytes overwrite older ones.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx         = head_q;
    ld_fwd_data = '0;
    ld_fwd_strb = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (mem_q[idx].addr[AW-1:2] == ld_addr[AW-1:2])) begin
        for (int b = 0; b < SW; b++) begin
          if (mem_q[idx].strb[b]) begin
            ld_fwd_data[8*b +: 8] = mem_q[idx].wdata[8*b +: 8];
            ld_fwd_strb[b]        = 1'b1;
          end
        end
      end
    end
  end
`else
  // No forwarding: the pipeline stalls loads on ld_hit until the buffer drains.
  assign ld_fwd_data = '0;
  assign ld_fwd_strb = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: vector table, directed corner sequences, and randomized
// traffic checked against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [3:0]  in_strb;
  logic [31:0] in_wdata;
  logic        in_uncached;
  logic        dc_valid;
  logic        dc_ready;
  logic [31:0] dc_addr;
  logic [3:0]  dc_strb;
  logic [31:0] dc_wdata;
  logic        dc_uncached;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_fwd_data;
  logic [3:0]  ld_fwd_strb;
  logic        empty;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_strb(in_strb), .in_wdata(in_wdata), .in_uncached(in_uncached),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_addr(dc_addr),
    .dc_strb(dc_strb), .dc_wdata(dc_wdata), .dc_uncached(dc_uncached),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
    .ld_fwd_strb(ld_fwd_strb), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer as a plain ordered queue of stores.
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        unc;
  } ent_t;
  ent_t q[$];

  function automatic logic model_hit(input logic [31:0] la);
    logic h;
    h = 1'b0;
    foreach (q[k]) if (q[k].addr[31:2] == la[31:2]) h = 1'b1;
    return h;
  endfunction

  task automatic model_fwd(input logic [31:0] la, output logic [31:0] d, output logic [3:0] s);
    d = '0;
    s = '0;
`ifdef STB_FWD_EN
    foreach (q[k]) begin
      if (q[k].addr[31:2] == la[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[k].strb[b]) begin
            d[8*b +: 8] = q[k].wdata[8*b +: 8];
            s[b]        = 1'b1;
          end
        end
      end
    end
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic u, input logic r, input logic [31:0] la);
    in_valid    = v;
    in_addr     = a;
    in_strb     = s;
    in_wdata    = d;
    in_uncached = u;
    dc_ready    = r;
    ld_addr     = la;
  endtask

  // Advance one clock; inputs change only just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    q.delete();
  endtask

  typedef struct {
    logic        v;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic        rdy;
    logic [31:0] la;
    logic        e_rdy;
    logic        e_vld;
    logic [31:0] e_addr;
    logic        e_empty;
    logic        e_hit;
  } vec_t;
  vec_t tv[14];

  initial begin
    logic [31:0] ed;
    logic [3:0]  es;

    reset = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'h1000);
    #2 reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dc_valid", dc_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ld_hit", ld_hit, 0);
    chk("rst_fwd_strb", ld_fwd_strb, 0);
    chk("rst_fwd_data", ld_fwd_data, 0);
    @(negedge clk);
    reset = 1'b1;

    // Each row lists the inputs and the outputs expected before that row's clock edge.
    tv[0]  = '{1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0};
    tv[1]  = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 32'h1000, 1'b1, 1'b1, 32'h1000, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 32'h1100, 4'h0, 32'h12345678, 1'b0, 32'h1100, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0};
    tv[3]  = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 32'h1100, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0};
    tv[4]  = '{1'b1, 32'h100,  4'hF, 32'h11,       1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b1, 1'b0};
    tv[5]  = '{1'b1, 32'h104,  4'hF, 32'h22,       1'b0, 32'h104,  1'b1, 1'b1, 32'h100,  1'b0, 1'b0};
    tv[6]  = '{1'b1, 32'h108,  4'hF, 32'h33,       1'b0, 32'h104,  1'b1, 1'b1, 32'h100,  1'b0, 1'b1};
    tv[7]  = '{1'b1, 32'h10C,  4'hF, 32'h44,       1'b0, 32'h10C,  1'b1, 1'b1, 32'h100,  1'b0, 1'b0};
    tv[8]  = '{1'b1, 32'h110,  4'hF, 32'h55,       1'b0, 32'h10C,  1'b0, 1'b1, 32'h100,  1'b0, 1'b1};
    tv[9]  = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 32'h110,  1'b0, 1'b1, 32'h100,  1'b0, 1'b0};
    tv[10] = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 32'h100,  1'b1, 1'b1, 32'h104,  1'b0, 1'b0};
    tv[11] = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 32'h108,  1'b1, 1'b1, 32'h108,  1'b0, 1'b1};
    tv[12] = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 32'h110,  1'b1, 1'b1, 32'h10C,  1'b0, 1'b0};
    tv[13] = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 32'h110,  1'b1, 1'b0, 32'h0,    1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(tv[i].v, tv[i].a, tv[i].s, tv[i].d, 1'b0, tv[i].rdy, tv[i].la);
      #1;
      chk($sformatf("vec%0d_in_ready", i), in_ready, tv[i].e_rdy);
      chk($sformatf("vec%0d_dc_valid", i), dc_valid, tv[i].e_vld);
      if (tv[i].e_vld) chk($sformatf("vec%0d_dc_addr", i), dc_addr, tv[i].e_addr);
      chk($sformatf("vec%0d_empty", i), empty, tv[i].e_empty);
      chk($sformatf("vec%0d_ld_hit", i), ld_hit, tv[i].e_hit);
      if (i == 1) chk("vec1_dc_wdata", dc_wdata, 32'hDEADBEEF);
      step();
    end

    // Simultaneous push and pop at count=2, then at full.
    apply_reset();
    drive(1'b1, 32'h200, 4'hF, 32'hA0, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h204, 4'hF, 32'hA1, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h208, 4'hF, 32'hA2, 1'b1, 1'b1, '0); #1;
    chk("pp2_head", dc_addr, 32'h200);
    chk("pp2_in_ready", in_ready, 1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, '0); #1;
    chk("pp2_next", dc_addr, 32'h204);
    chk("pp2_uncached0", dc_uncached, 0);
    step(); #1;
    chk("pp2_last", dc_addr, 32'h208);
    chk("pp2_uncached1", dc_uncached, 1);
    step(); #1;
    chk("pp2_empty", empty, 1);
    drive(1'b1, 32'h300, 4'hF, 32'hB0, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h304, 4'hF, 32'hB1, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h308, 4'hF, 32'hB2, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h30C, 4'hF, 32'hB3, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h310, 4'hF, 32'hB4, 1'b0, 1'b1, '0); #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_head", dc_addr, 32'h300);
    step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, '0); #1;
    chk("full_in_ready_after_pop", in_ready, 1);
    chk("full_d1", dc_addr, 32'h304); step(); #1;
    chk("full_d2", dc_addr, 32'h308); step(); #1;
    chk("full_d3", dc_addr, 32'h30C); step(); #1;
    chk("full_refused_empty", empty, 1);

    // Load probe with overlapping stores to the same word.
    apply_reset();
    drive(1'b1, 32'h2000, 4'h3, 32'h0000AABB, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h2002, 4'h4, 32'h00CC0000, 1'b0, 1'b0, '0); step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'h2001); #1;
    chk("fwd_hit", ld_hit, 1);
`ifdef STB_FWD_EN
    chk("fwd_strb", ld_fwd_strb, 4'h7);
    chk("fwd_data", ld_fwd_data, 32'h00CCAABB);
`else
    chk("fwd_strb", ld_fwd_strb, 4'h0);
    chk("fwd_data", ld_fwd_data, 32'h0);
`endif
    drive(1'b1, 32'h2000, 4'h1, 32'h000000EE, 1'b0, 1'b0, 32'h2001); step(); #1;
`ifdef STB_FWD_EN
    chk("fwd_young_data", ld_fwd_data, 32'h00CCAAEE);
`else
    chk("fwd_young_data", ld_fwd_data, 32'h0);
`endif
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'h2004); #1;
    chk("fwd_miss_hit", ld_hit, 0);
    chk("fwd_miss_strb", ld_fwd_strb, 0);

    // Reset asserted while the head is being presented.
    apply_reset();
    drive(1'b1, 32'h400, 4'hF, 32'h1, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h404, 4'hF, 32'h2, 1'b0, 1'b0, '0); step();
    drive(1'b1, 32'h408, 4'hF, 32'h3, 1'b0, 1'b0, '0); step();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 32'h404); #1;
    chk("mid_pre_valid", dc_valid, 1);
    chk("mid_pre_hit", ld_hit, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_async_valid", dc_valid, 0);
    chk("mid_async_ready", in_ready, 1);
    chk("mid_async_empty", empty, 1);
    chk("mid_async_hit", ld_hit, 0);
    chk("mid_async_fwd", ld_fwd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    step(); #1;
    chk("mid_post_empty", empty, 1);
    chk("mid_post_hit", ld_hit, 0);
    chk("mid_post_valid", dc_valid, 0);

    // Randomized traffic against the queue model.
    apply_reset();
    for (int n = 0; n < 600; n++) begin
      logic mpush, mpop;
      ent_t e;
      drive($urandom_range(0, 9) < 7,
            32'h5000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            32'h5000 + 32'($urandom_range(0, 4)) * 4 + 32'($urandom_range(0, 3)));
      #1;
      chk("rnd_in_ready", in_ready, q.size() != DEPTH);
      chk("rnd_dc_valid", dc_valid, q.size() != 0);
      chk("rnd_empty", empty, q.size() == 0);
      if (q.size() != 0) begin
        chk("rnd_dc_addr", dc_addr, q[0].addr);
        chk("rnd_dc_strb", dc_strb, q[0].strb);
        chk("rnd_dc_wdata", dc_wdata, q[0].wdata);
        chk("rnd_dc_unc", dc_uncached, q[0].unc);
      end
      chk("rnd_ld_hit", ld_hit, model_hit(ld_addr));
      model_fwd(ld_addr, ed, es);
      chk("rnd_fwd_data", ld_fwd_data, ed);
      chk("rnd_fwd_strb", ld_fwd_strb, es);
      mpush = in_valid && (q.size() != DEPTH) && (in_strb != 4'h0);
      mpop  = dc_ready && (q.size() != 0);
      e = '{in_addr, in_strb, in_wdata, in_uncached};
      @(posedge clk);
      if (mpop) void'(q.pop_front());
      if (mpush) q.push_back(e);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
